// File: rtl/dest_reg_pipe.sv
// dest_reg_pipe: picks the write destination of the instruction leaving decode and
// carries it, with a valid bit, through DEPTH post-decode stages. Per-source RAW
// hits are reported one-hot on the youngest in-flight writer.
// Optional feature macro: STALL_CNT_EN (saturating 16-bit stall-cycle counter).
module dest_reg_pipe #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LINK_REG = 31
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_W-1:0]         rt,
  input  logic [ADDR_W-1:0]         rd,
  input  logic [1:0]                selectCode,
  input  logic                      regWrite,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [ADDR_W-1:0]         rsQ,
  input  logic [ADDR_W-1:0]         rtQ,
  output logic [ADDR_W-1:0]         destOut,
  output logic [DEPTH*ADDR_W-1:0]   stageDest,
  output logic [DEPTH-1:0]          stageValid,
  output logic [DEPTH-1:0]          rsHit,
  output logic [DEPTH-1:0]          rtHit,
  output logic                      hazard,
  output logic [15:0]               stallCnt
);

  localparam logic [ADDR_W-1:0] LinkIdx = ADDR_W'(LINK_REG);

  logic              w_bubble;
  logic              w_entry_valid;
  logic [ADDR_W-1:0] w_entry_dest;
  logic [DEPTH-1:0]  w_rs_match;
  logic [DEPTH-1:0]  w_rt_match;

  logic [ADDR_W-1:0] r_dest [DEPTH];
  logic [DEPTH-1:0]  r_valid;

  // Destination select for the decode instruction; 11 means no destination.
  always_comb begin
    destOut = '0;
    unique case (selectCode)
      2'b00:   destOut = rt;
      2'b01:   destOut = rd;
      2'b10:   destOut = LinkIdx;
      default: destOut = '0;
    endcase
  end

  // Stage-0 entry; register 0 is never tracked, bubbles carry a zeroed dest.
  always_comb begin
    w_bubble      = stall | flush;
    w_entry_valid = regWrite & (destOut != '0) & (selectCode != 2'b11) & ~w_bubble;
    w_entry_dest  = w_bubble ? '0 : destOut;
  end

  // Pipe always advances; the oldest entry falls off the end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_dest[i] <= '0;
      r_valid <= '0;
    end else begin
      r_dest[0]  <= w_entry_dest;
      r_valid[0] <= w_entry_valid;
      for (int i = 1; i < DEPTH; i++) begin
        r_dest[i]  <= r_dest[i-1];
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  // Flatten stage destinations onto the output bus, stage i at [i*ADDR_W +: ADDR_W].
  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign stageDest[g*ADDR_W +: ADDR_W] = r_dest[g];
  end
  assign stageValid = r_valid;

  // Raw per-stage matches; a zero query never matches.
  always_comb begin
    w_rs_match = '0;
    w_rt_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_rs_match[i] = r_valid[i] & (r_dest[i] == rsQ) & (rsQ != '0);
      w_rt_match[i] = r_valid[i] & (r_dest[i] == rtQ) & (rtQ != '0);
    end
  end

  // Keep only the lowest set bit (youngest writer): x & -x.
  always_comb begin
    rsHit  = w_rs_match & (~w_rs_match + DEPTH'(1));
    rtHit  = w_rt_match & (~w_rt_match + DEPTH'(1));
    hazard = (|rsHit) | (|rtHit);
  end

`ifdef STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating stall-cycle counter, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stallCnt = r_stall_cnt;
`else
  assign stallCnt = 16'h0000;
`endif

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Self-checking bench for dest_reg_pipe (default parameters). The reference model
// keeps a history queue of issued entries, youngest first, and derives stage
// contents and hits from it.
module tb_dest_reg_pipe;

  localparam int AW = 5;
  localparam int DP = 3;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] rt, rd, rsQ, rtQ;
  logic [1:0]    selectCode;
  logic          regWrite, stall, flush;
  logic [AW-1:0]    destOut;
  logic [DP*AW-1:0] stageDest;
  logic [DP-1:0]    stageValid, rsHit, rtHit;
  logic             hazard;
  logic [15:0]      stallCnt;

  int checks;
  int failures;

  typedef struct {
    logic [AW-1:0] d;
    logic          v;
  } entry_t;

  entry_t hist[$];
  int     m_cnt;

  dest_reg_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rt         (rt),
    .rd         (rd),
    .selectCode (selectCode),
    .regWrite   (regWrite),
    .stall      (stall),
    .flush      (flush),
    .rsQ        (rsQ),
    .rtQ        (rtQ),
    .destOut    (destOut),
    .stageDest  (stageDest),
    .stageValid (stageValid),
    .rsHit      (rsHit),
    .rtHit      (rtHit),
    .hazard     (hazard),
    .stallCnt   (stallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW-1:0] m_dest_sel();
    case (selectCode)
      2'd0:    return rt;
      2'd1:    return rd;
      2'd2:    return AW'(31);
      default: return '0;
    endcase
  endfunction

  function automatic logic [DP-1:0] m_valid();
    logic [DP-1:0] r = '0;
    for (int k = 0; k < hist.size() && k < DP; k++) r[k] = hist[k].v;
    return r;
  endfunction

  function automatic logic [DP*AW-1:0] m_dest_flat();
    logic [DP*AW-1:0] r = '0;
    for (int k = 0; k < hist.size() && k < DP; k++) r[k*AW +: AW] = hist[k].d;
    return r;
  endfunction

  function automatic logic [DP-1:0] m_hit(input logic [AW-1:0] q);
    logic [DP-1:0] r = '0;
    if (q == 0) return r;
    for (int k = 0; k < hist.size() && k < DP; k++) begin
      if (hist[k].v && hist[k].d == q) begin
        r[k] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] m_stall_cnt();
`ifdef STALL_CNT_EN
    return (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
`else
    return 16'h0000;
`endif
  endfunction

  // One rising edge; the model captures the inputs present at that edge.
  task automatic tick();
    entry_t e;
    logic [AW-1:0] d;
    d   = m_dest_sel();
    e.v = regWrite && (d != 0) && (selectCode != 2'd3) && !stall && !flush;
    e.d = (stall || flush) ? '0 : d;
    @(posedge clk);
    if (rst_n) begin
      hist.push_front(e);
      if (hist.size() > DP) void'(hist.pop_back());
      if (stall) m_cnt++;
    end
    #1;
  endtask

  task automatic idle();
    regWrite = 0; stall = 0; flush = 0; selectCode = 2'd3;
    rsQ = 0; rtQ = 0; rt = 0; rd = 0;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < DP; i++) tick();
  endtask

  task automatic test_reset();
    selectCode = 2'd1; regWrite = 1;
    rd = 5'd3; tick();
    rd = 5'd6; tick();
    rd = 5'd12; tick();
    checks++;
    if (stageValid !== 3'b111) begin
      failures++; $display("FAIL reset_fill stageValid got=%b exp=111", stageValid);
    end
    rsQ = 5'd3; #1;
    checks++;
    if (hazard !== 1'b1 || rsHit !== 3'b100) begin
      failures++; $display("FAIL reset_prehit hazard=%b rsHit=%b exp 1/100", hazard, rsHit);
    end
    rst_n = 0; #1;
    hist.delete(); m_cnt = 0;
    checks++;
    if (stageValid !== '0 || stageDest !== '0) begin
      failures++; $display("FAIL reset_async valid=%b dest=%h exp 0", stageValid, stageDest);
    end
    checks++;
    if (hazard !== 1'b0 || rsHit !== '0 || stallCnt !== 16'h0) begin
      failures++;
      $display("FAIL reset_outs hazard=%b rsHit=%b stallCnt=%h exp 0", hazard, rsHit, stallCnt);
    end
    rd = 5'd17; #1;
    checks++;
    if (destOut !== 5'd17) begin
      failures++; $display("FAIL reset_destout got=%0d exp=17", destOut);
    end
    rst_n = 1;
    idle();
    tick(); tick();
    checks++;
    if (stageValid !== '0 || hazard !== 1'b0 || stallCnt !== 16'h0) begin
      failures++;
      $display("FAIL reset_release valid=%b hazard=%b cnt=%h exp 0", stageValid, hazard, stallCnt);
    end
  endtask

  task automatic test_select();
    logic [AW-1:0] exp_d [4];
    exp_d[0] = 5'd5; exp_d[1] = 5'd9; exp_d[2] = 5'd31; exp_d[3] = 5'd0;
    idle();
    rt = 5'd5; rd = 5'd9; regWrite = 1;
    for (int s = 0; s < 4; s++) begin
      selectCode = 2'(s); #1;
      checks++;
      if (destOut !== exp_d[s]) begin
        failures++; $display("FAIL select_%0d destOut got=%0d exp=%0d", s, destOut, exp_d[s]);
      end
    end
    tick();
    checks++;
    if (stageValid[0] !== 1'b0) begin
      failures++; $display("FAIL select_none stageValid[0] got=%b exp=0", stageValid[0]);
    end
  endtask

  task automatic test_shift_hit();
    logic [DP-1:0] exp_h [4];
    exp_h[0] = 3'b001; exp_h[1] = 3'b010; exp_h[2] = 3'b100; exp_h[3] = 3'b000;
    drain();
    selectCode = 2'd1; rd = 5'd9; regWrite = 1; rsQ = 5'd9;
    tick();
    regWrite = 0; selectCode = 2'd3;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      checks++;
      if (rsHit !== exp_h[c] || hazard !== (exp_h[c] != 0)) begin
        failures++;
        $display("FAIL shift_hit_c%0d rsHit=%b hazard=%b exp=%b", c + 1, rsHit, hazard, exp_h[c]);
      end
    end
  endtask

  task automatic test_youngest();
    drain();
    selectCode = 2'd0; rt = 5'd7; regWrite = 1;
    tick(); tick();
    idle(); rtQ = 5'd7; #1;
    checks++;
    if (stageValid !== 3'b011 || rtHit !== 3'b001) begin
      failures++;
      $display("FAIL youngest valid=%b rtHit=%b exp 011/001", stageValid, rtHit);
    end
  endtask

  task automatic test_zero_bubble();
    drain();
    selectCode = 2'd1; rd = 5'd0; regWrite = 1;
    tick();
    idle(); rsQ = 5'd0; #1;
    checks++;
    if (stageValid[0] !== 1'b0 || rsHit !== '0) begin
      failures++; $display("FAIL zero_dest valid0=%b rsHit=%b exp 0/000", stageValid[0], rsHit);
    end
    selectCode = 2'd1; rd = 5'd4; regWrite = 1; stall = 1; flush = 1;
    tick();
    idle(); rsQ = 5'd4; #1;
    checks++;
    if (stageValid[0] !== 1'b0 || stageDest[AW-1:0] !== '0 || rsHit !== '0) begin
      failures++;
      $display("FAIL bubble valid0=%b dest0=%0d rsHit=%b exp 0/0/000",
               stageValid[0], stageDest[AW-1:0], rsHit);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      rt = AW'($urandom_range(0, 7));
      rd = AW'($urandom_range(0, 7));
      rsQ = AW'($urandom_range(0, 7));
      rtQ = AW'($urandom_range(0, 7));
      selectCode = 2'($urandom_range(0, 3));
      regWrite = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 5) == 0);
      #1;
      checks++;
      if (destOut !== m_dest_sel() || stageValid !== m_valid() || stageDest !== m_dest_flat()
          || rsHit !== m_hit(rsQ) || rtHit !== m_hit(rtQ)
          || hazard !== ((m_hit(rsQ) | m_hit(rtQ)) != 0) || stallCnt !== m_stall_cnt()) begin
        failures++;
        $display("FAIL random_%0d dOut=%0d/%0d v=%b/%b dst=%h/%h rs=%b/%b rt=%b/%b hz=%b cnt=%h/%h",
                 n, destOut, m_dest_sel(), stageValid, m_valid(), stageDest, m_dest_flat(),
                 rsHit, m_hit(rsQ), rtHit, m_hit(rtQ), hazard, stallCnt, m_stall_cnt());
      end
      tick();
    end
  endtask

  task automatic test_counter();
    idle();
    rst_n = 0; #1; rst_n = 1;
    hist.delete(); m_cnt = 0;
    stall = 1;
    for (int i = 0; i < 5; i++) tick();
    stall = 0; flush = 1;
    for (int i = 0; i < 3; i++) tick();
    flush = 0;
`ifdef STALL_CNT_EN
    checks++;
    if (stallCnt !== 16'd5) begin
      failures++; $display("FAIL cnt_five got=%0d exp=5", stallCnt);
    end
    stall = 1;
    for (int i = 0; i < 70000; i++) tick();
    checks++;
    if (stallCnt !== 16'hFFFF) begin
      failures++; $display("FAIL cnt_saturate got=%h exp=ffff", stallCnt);
    end
    tick(); tick();
    stall = 0;
    checks++;
    if (stallCnt !== 16'hFFFF) begin
      failures++; $display("FAIL cnt_hold got=%h exp=ffff", stallCnt);
    end
`else
    checks++;
    if (stallCnt !== 16'h0000) begin
      failures++; $display("FAIL cnt_disabled got=%h exp=0000", stallCnt);
    end
`endif
  endtask

  initial begin
    checks = 0; failures = 0; m_cnt = 0;
    rst_n = 0;
    idle();
    #12;
    checks++;
    if (stageValid !== '0 || hazard !== 1'b0 || stallCnt !== 16'h0) begin
      failures++;
      $display("FAIL init_reset valid=%b hazard=%b cnt=%h exp 0", stageValid, hazard, stallCnt);
    end
    rst_n = 1;
    tick();
    test_reset();
    test_select();
    test_shift_hit();
    test_youngest();
    test_zero_bubble();
    test_random();
    test_counter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
